// File: rtl/io_stage_params.sv
`default_nettype none
// ============================================================================
// io_stage_params
// Shared types and defaults for the IO-stage memory request controller.
// Revision: 1.0
// ============================================================================
package io_stage_params;

    localparam int c_MAX_OUTSTANDING = 2;
    localparam int c_ADDRESS_WIDTH   = 32;
    localparam int c_DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } memory_size_t;

    typedef struct packed {
        logic                       write;
        memory_size_t               size;
        logic [c_ADDRESS_WIDTH-1:0] address;
        logic [3:0]                 write_strobe;
        logic [c_DATA_WIDTH-1:0]    write_data;
    } memory_request_t;

endpackage
`default_nettype wire

// File: rtl/io_stage_response_tag_fifo.sv
`default_nettype none
// ============================================================================
// io_stage_response_tag_fifo
// In-order FIFO of per-transaction tags, popped as responses return.
// Revision: 1.0
// ============================================================================
module io_stage_response_tag_fifo #(
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic [TAG_WIDTH-1:0] push_tag,
    input  logic                 pop,
    output logic [TAG_WIDTH-1:0] head_tag
);

    localparam int c_PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [c_PTR_WIDTH-1:0]   c_LAST_PTR   = c_PTR_WIDTH'(DEPTH - 1);
    localparam logic [c_COUNT_WIDTH-1:0] c_FULL_COUNT = c_COUNT_WIDTH'(DEPTH);

    logic [TAG_WIDTH-1:0]     r_tags [DEPTH];
    logic [c_PTR_WIDTH-1:0]   r_wr_ptr;
    logic [c_PTR_WIDTH-1:0]   r_rd_ptr;
    logic [c_COUNT_WIDTH-1:0] r_count;
    logic                     w_push;
    logic                     w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PTR_WIDTH-1:0] f_next(input logic [c_PTR_WIDTH-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_push   = push && (r_count != c_FULL_COUNT);
    assign w_pop    = pop && (r_count != '0);
    assign head_tag = (r_count != '0) ? r_tags[r_rd_ptr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tags[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= push_tag;
                r_wr_ptr         <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            r_count <= r_count + c_COUNT_WIDTH'(w_push) - c_COUNT_WIDTH'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_stage_memory_request_controller.sv
`default_nettype none
// ============================================================================
// io_stage_memory_request_controller
// Issues IO-stage loads/stores on the data bus and returns in-order responses.
// Revision: 1.0
// ============================================================================
module io_stage_memory_request_controller
    import io_stage_params::*;
#(
    parameter int MAX_OUTSTANDING = c_MAX_OUTSTANDING,
    parameter int ADDRESS_WIDTH   = c_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = c_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_write,
    input  logic [1:0]               issue_size,
    input  logic [ADDRESS_WIDTH-1:0] issue_address,
    input  logic [3:0]               issue_write_strobe,
    input  logic [DATA_WIDTH-1:0]    issue_write_data,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic                     data_request,
    output logic                     data_write,
    output logic [1:0]               data_size,
    output logic [ADDRESS_WIDTH-1:0] data_address,
    output logic [3:0]               data_write_strobe,
    output logic [DATA_WIDTH-1:0]    data_write_data,
    input  logic                     data_address_ok,
    input  logic                     data_data_ok,
    input  logic [DATA_WIDTH-1:0]    data_read_data,
    output logic                     response_valid,
    output logic                     response_write,
    output logic [DATA_WIDTH-1:0]    response_data,
    input  logic                     response_ready,
    output logic                     busy
);

    localparam int c_COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_OCC_WIDTH   = c_COUNT_WIDTH + 1;
    localparam logic [c_OCC_WIDTH-1:0] c_OCC_LIMIT = c_OCC_WIDTH'(MAX_OUTSTANDING);

    memory_request_t          r_issue_req;
    logic                     r_issue_held;
    logic                     r_issue_cancelled;
    logic [c_COUNT_WIDTH-1:0] r_pending_count;
    logic [c_COUNT_WIDTH-1:0] r_cancel_count;
    logic                     r_buf_full;
    logic                     r_buf_write;
    logic [DATA_WIDTH-1:0]    r_buf_data;

    logic                     w_addr_hs;
    logic                     w_issue_fire;
    logic                     w_drop;
    logic                     w_fwd;
    logic                     w_tag_head;
    logic [c_OCC_WIDTH-1:0]   w_occupancy;

    assign w_addr_hs = r_issue_held && data_address_ok;
    assign w_drop    = data_data_ok && (r_cancel_count != '0);
    assign w_fwd     = data_data_ok && !w_drop;

    // The held request counts against the limit even while it hands off,
    // so a same-cycle refill only happens when a slot is genuinely free.
    assign w_occupancy  = c_OCC_WIDTH'(r_pending_count) + c_OCC_WIDTH'(r_buf_full)
                        + c_OCC_WIDTH'(r_issue_held);
    assign issue_ready  = !reset && (!r_issue_held || w_addr_hs) && !flush
                        && (w_occupancy < c_OCC_LIMIT);
    assign w_issue_fire = issue_valid && issue_ready;

    assign data_request      = r_issue_held;
    assign data_write        = r_issue_req.write;
    assign data_size         = r_issue_req.size;
    assign data_address      = r_issue_req.address;
    assign data_write_strobe = r_issue_req.write_strobe;
    assign data_write_data   = r_issue_req.write_data;

    assign busy = r_issue_held || (r_pending_count != '0) || r_buf_full
               || (r_cancel_count != '0);

    always_comb begin
        response_valid = r_buf_full || w_fwd;
        response_write = 1'b0;
        response_data  = '0;
        if (r_buf_full) begin
            response_write = r_buf_write;
            response_data  = r_buf_data;
        end else if (w_fwd) begin
            response_write = w_tag_head;
            response_data  = data_read_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issue_held      <= 1'b0;
            r_issue_cancelled <= 1'b0;
            r_issue_req       <= '0;
        end else if (w_issue_fire) begin
            r_issue_held      <= 1'b1;
            r_issue_cancelled <= 1'b0;
            r_issue_req       <= '{write:        issue_write,
                                   size:         memory_size_t'(issue_size),
                                   address:      issue_address,
                                   write_strobe: issue_write_strobe,
                                   write_data:   issue_write_data};
        end else if (w_addr_hs) begin
            r_issue_held      <= 1'b0;
            r_issue_cancelled <= 1'b0;
        end else if (flush && r_issue_held) begin
            // A raised request stays on the bus; only its response is doomed.
            r_issue_cancelled <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending_count <= '0;
            r_cancel_count  <= '0;
        end else begin
            r_pending_count <= r_pending_count + c_COUNT_WIDTH'(w_addr_hs)
                             - c_COUNT_WIDTH'(data_data_ok);
            if (flush) begin
                r_cancel_count <= r_pending_count + c_COUNT_WIDTH'(w_addr_hs)
                                - c_COUNT_WIDTH'(data_data_ok);
            end else begin
                r_cancel_count <= r_cancel_count
                                + c_COUNT_WIDTH'(w_addr_hs && r_issue_cancelled)
                                - c_COUNT_WIDTH'(w_drop);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_full  <= 1'b0;
            r_buf_write <= 1'b0;
            r_buf_data  <= '0;
        end else if (flush) begin
            r_buf_full <= 1'b0;
        end else if (r_buf_full) begin
            if (response_ready) begin
                r_buf_full  <= w_fwd;
                r_buf_write <= w_tag_head;
                r_buf_data  <= data_read_data;
            end
        end else if (w_fwd && !response_ready) begin
            r_buf_full  <= 1'b1;
            r_buf_write <= w_tag_head;
            r_buf_data  <= data_read_data;
        end
    end

    // Only live transactions are tagged; cancelled ones are tracked by count.
    io_stage_response_tag_fifo #(
        .DEPTH     (MAX_OUTSTANDING),
        .TAG_WIDTH (1)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (w_addr_hs && !r_issue_cancelled),
        .push_tag (r_issue_req.write),
        .pop      (w_fwd),
        .head_tag (w_tag_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_io_stage_memory_request_controller.sv
`default_nettype none
// ============================================================================
// tb_io_stage_memory_request_controller
// Directed vector table plus hand-written flush/backpressure/reset sequences.
// Revision: 1.0
// ============================================================================
module tb_io_stage_memory_request_controller;

    localparam int MAX_OUT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_write = 1'b0;
    logic [1:0]  issue_size = 2'd0;
    logic [31:0] issue_address = '0;
    logic [3:0]  issue_write_strobe = '0;
    logic [31:0] issue_write_data = '0;
    logic        issue_ready;
    logic        flush = 1'b0;
    logic        data_request;
    logic        data_write;
    logic [1:0]  data_size;
    logic [31:0] data_address;
    logic [3:0]  data_write_strobe;
    logic [31:0] data_write_data;
    logic        data_address_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_read_data = '0;
    logic        response_valid;
    logic        response_write;
    logic [31:0] response_data;
    logic        response_ready = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    io_stage_memory_request_controller #(
        .MAX_OUTSTANDING (MAX_OUT),
        .ADDRESS_WIDTH   (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .issue_valid        (issue_valid),
        .issue_write        (issue_write),
        .issue_size         (issue_size),
        .issue_address      (issue_address),
        .issue_write_strobe (issue_write_strobe),
        .issue_write_data   (issue_write_data),
        .issue_ready        (issue_ready),
        .flush              (flush),
        .data_request       (data_request),
        .data_write         (data_write),
        .data_size          (data_size),
        .data_address       (data_address),
        .data_write_strobe  (data_write_strobe),
        .data_write_data    (data_write_data),
        .data_address_ok    (data_address_ok),
        .data_data_ok       (data_data_ok),
        .data_read_data     (data_read_data),
        .response_valid     (response_valid),
        .response_write     (response_write),
        .response_data      (response_data),
        .response_ready     (response_ready),
        .busy               (busy)
    );

    typedef struct {
        logic        iv, iw;
        logic [31:0] ia, iwd;
        logic        aok, dok;
        logic [31:0] rd;
        logic        rr, fl;
        logic        e_ready, e_req, e_write;
        logic [31:0] e_addr, e_wdata;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_rw, e_busy;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(
        input logic iv, input logic iw, input logic [31:0] ia, input logic [31:0] iwd,
        input logic aok, input logic dok, input logic [31:0] rd, input logic rr, input logic fl,
        input logic er, input logic ereq, input logic ew, input logic [31:0] ea,
        input logic [31:0] ewd, input logic erv, input logic [31:0] erd,
        input logic erw, input logic eb);
        vec_t v;
        v.iv = iv; v.iw = iw; v.ia = ia; v.iwd = iwd;
        v.aok = aok; v.dok = dok; v.rd = rd; v.rr = rr; v.fl = fl;
        v.e_ready = er; v.e_req = ereq; v.e_write = ew; v.e_addr = ea; v.e_wdata = ewd;
        v.e_rv = erv; v.e_rdata = erd; v.e_rw = erw; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic step(input logic iv, input logic iw, input logic [31:0] ia,
                        input logic [31:0] iwd, input logic aok, input logic dok,
                        input logic [31:0] rd, input logic rr, input logic fl);
        @(posedge clock);
        #1;
        issue_valid        = iv;
        issue_write        = iw;
        issue_size         = 2'd2;
        issue_address      = ia;
        issue_write_strobe = iw ? 4'hF : 4'h0;
        issue_write_data   = iwd;
        data_address_ok    = aok;
        data_data_ok       = dok;
        data_read_data     = rd;
        response_ready     = rr;
        flush              = fl;
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (dut.r_pending_count > MAX_OUT || dut.r_cancel_count > dut.r_pending_count) begin
                errors++;
                $display("FAIL count_bounds: pending %0d cancel %0d limit %0d",
                         dut.r_pending_count, dut.r_cancel_count, MAX_OUT);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single load, stalled store, outstanding limit with mixed responses
        vecs[0]  = mk(1,0,32'h1000,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(0,0,0,0, 0,0,0,1,0, 0,1,0,32'h1000,0, 0,0,0,1);
        vecs[2]  = mk(0,0,0,0, 1,0,0,1,0, 1,1,0,32'h1000,0, 0,0,0,1);
        vecs[3]  = mk(0,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,1);
        vecs[4]  = mk(0,0,0,0, 0,1,32'hDEADBEEF,1,0, 1,0,0,0,0, 1,32'hDEADBEEF,0,1);
        vecs[5]  = mk(0,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,0);
        vecs[6]  = mk(1,1,32'h2000,32'h12345678, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,0);
        for (int i = 7; i <= 11; i++)
            vecs[i] = mk(1,0,32'h3000,0, 0,0,0,1,0, 0,1,1,32'h2000,32'h12345678, 0,0,0,1);
        vecs[12] = mk(1,0,32'h3000,0, 1,0,0,1,0, 1,1,1,32'h2000,32'h12345678, 0,0,0,1);
        vecs[13] = mk(0,0,0,0, 1,0,0,1,0, 0,1,0,32'h3000,0, 0,0,0,1);
        vecs[14] = mk(1,0,32'h4000,0, 0,0,0,1,0, 0,0,0,0,0, 0,0,0,1);
        vecs[15] = mk(1,0,32'h4000,0, 0,1,0,1,0, 0,0,0,0,0, 1,0,1,1);
        vecs[16] = mk(1,0,32'h4000,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,1);
        vecs[17] = mk(0,0,0,0, 1,0,0,1,0, 0,1,0,32'h4000,0, 0,0,0,1);
        vecs[18] = mk(0,0,0,0, 0,1,32'h0BADF00D,1,0, 0,0,0,0,0, 1,32'h0BADF00D,0,1);
        vecs[19] = mk(0,0,0,0, 0,1,32'hCAFE0001,1,0, 1,0,0,0,0, 1,32'hCAFE0001,0,1);
        vecs[20] = mk(0,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,0);

        #12;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_request", data_request, 0);
        chk("rst_address", data_address, 0);
        chk("rst_resp_valid", response_valid, 0);
        chk("rst_resp_data", response_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].iw, vecs[i].ia, vecs[i].iwd, vecs[i].aok,
                 vecs[i].dok, vecs[i].rd, vecs[i].rr, vecs[i].fl);
            chk($sformatf("v%0d_issue_ready", i), issue_ready, vecs[i].e_ready);
            chk($sformatf("v%0d_request", i), data_request, vecs[i].e_req);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_write", i), data_write, vecs[i].e_write);
                chk($sformatf("v%0d_address", i), data_address, vecs[i].e_addr);
                chk($sformatf("v%0d_wdata", i), data_write_data, vecs[i].e_wdata);
                chk($sformatf("v%0d_size", i), data_size, 2'd2);
                chk($sformatf("v%0d_strobe", i), data_write_strobe,
                    vecs[i].e_write ? 4'hF : 4'h0);
            end
            chk($sformatf("v%0d_resp_valid", i), response_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_resp_data", i), response_data, vecs[i].e_rdata);
            chk($sformatf("v%0d_resp_write", i), response_write, vecs[i].e_rw);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
        end

        // Flush with two pending loads: both responses are discarded
        step(1,0,32'h5000,0, 0,0,0,1,0);
        chk("fp_issue0", issue_ready, 1);
        step(1,0,32'h5004,0, 1,0,0,1,0);
        chk("fp_issue1_b2b", issue_ready, 1);
        step(0,0,0,0, 1,0,0,1,0);
        chk("fp_req1_addr", data_address, 32'h5004);
        step(1,0,32'h5008,0, 0,0,0,1,1);
        chk("fp_ready_in_flush", issue_ready, 0);
        chk("fp_busy_flush", busy, 1);
        step(0,0,0,0, 0,1,32'h11,1,0);
        chk("fp_drop1_valid", response_valid, 0);
        chk("fp_drop1_data", response_data, 0);
        chk("fp_drop1_busy", busy, 1);
        step(0,0,0,0, 0,1,32'h22,1,0);
        chk("fp_drop2_valid", response_valid, 0);
        chk("fp_drop2_busy", busy, 1);
        idle();
        chk("fp_after_busy", busy, 0);
        chk("fp_after_ready", issue_ready, 1);

        // Flush while a request is held unaccepted
        step(1,0,32'h6000,0, 0,0,0,1,0);
        step(0,0,0,0, 0,0,0,1,1);
        chk("fh_req_in_flush", data_request, 1);
        chk("fh_addr_in_flush", data_address, 32'h6000);
        idle();
        chk("fh_req_kept", data_request, 1);
        chk("fh_busy", busy, 1);
        step(0,0,0,0, 1,0,0,1,0);
        chk("fh_req_hs", data_request, 1);
        step(1,0,32'h7000,0, 0,0,0,1,0);
        chk("fh_ready_new", issue_ready, 1);
        chk("fh_req_idle", data_request, 0);
        step(0,0,0,0, 1,1,32'h99,1,0);
        chk("fh_drop_valid", response_valid, 0);
        chk("fh_new_addr", data_address, 32'h7000);
        step(0,0,0,0, 0,1,32'h55,1,0);
        chk("fh_deliver_valid", response_valid, 1);
        chk("fh_deliver_data", response_data, 32'h55);
        chk("fh_deliver_write", response_write, 0);
        idle();
        chk("fh_busy_end", busy, 0);

        // Backpressure: buffered response, release, then flush of a buffered store ack
        step(1,0,32'h8000,0, 0,0,0,1,0);
        step(0,0,0,0, 1,0,0,1,0);
        step(0,0,0,0, 0,1,32'hA5A5A5A5,0,0);
        chk("bp_bypass_valid", response_valid, 1);
        chk("bp_bypass_data", response_data, 32'hA5A5A5A5);
        step(0,0,0,0, 0,0,0,0,0);
        chk("bp_held_valid", response_valid, 1);
        chk("bp_held_data", response_data, 32'hA5A5A5A5);
        chk("bp_held_busy", busy, 1);
        chk("bp_held_ready", issue_ready, 1);
        step(0,0,0,0, 0,0,0,1,0);
        chk("bp_release_valid", response_valid, 1);
        chk("bp_release_data", response_data, 32'hA5A5A5A5);
        idle();
        chk("bp_empty_valid", response_valid, 0);
        chk("bp_empty_busy", busy, 0);
        step(1,1,32'h8004,32'hDEADC0DE, 0,0,0,1,0);
        step(0,0,0,0, 1,0,0,1,0);
        chk("bp_store_write", data_write, 1);
        chk("bp_store_wdata", data_write_data, 32'hDEADC0DE);
        step(0,0,0,0, 0,1,32'h0,0,0);
        chk("bp_ack_valid", response_valid, 1);
        chk("bp_ack_write", response_write, 1);
        step(1,0,32'h9000,0, 0,0,0,0,1);
        chk("bp_flush_valid", response_valid, 1);
        chk("bp_flush_write", response_write, 1);
        chk("bp_flush_ready", issue_ready, 0);
        step(0,0,0,0, 0,0,0,0,0);
        chk("bp_cleared_valid", response_valid, 0);
        chk("bp_cleared_write", response_write, 0);
        chk("bp_cleared_busy", busy, 0);
        chk("bp_cleared_ready", issue_ready, 1);

        // Asynchronous reset with a transaction outstanding
        step(1,0,32'hA000,0, 0,0,0,1,0);
        step(0,0,0,0, 1,0,0,1,0);
        idle();
        chk("rm_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_request", data_request, 0);
        chk("rm_address", data_address, 0);
        chk("rm_issue_ready", issue_ready, 0);
        chk("rm_resp_valid", response_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        idle();
        chk("rm_after_ready", issue_ready, 1);
        chk("rm_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
